seg7_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It holds a frame of 4-bit hex characters in a shadow register and decodes one digit at a time to active-low segments. It scans the anodes round-robin at a programmable rate, with dead time between digits to suppress ghosting. It sits between the character-producing logic and the board's LED/anode pins, and supersedes the single-digit combinational decoder.

---
 rtl/seg7_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A frame of hex characters is loaded into a pending register and promoted to
// the active register only at a frame boundary, so a frame never tears.
// One digit is lit per slot, round-robin, with optional dead time at the start
// of each slot to suppress ghosting between digits.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   char_in      frame of 4-bit hex chars, digit k = char_in[4k+3:4k]
//   load         one-cycle strobe capturing char_in/blank_in into pending
//   blank_in     per-digit blank request, captured with load
//   an           anode enables, active-low, at most one bit low
//   led          segments {a,b,c,d,e,f,g}, active-low
//   frame_start  one-cycle pulse marking the start of the digit-0 slot
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zeros of each newly activated frame are added to
//   the blank mask (digit 0 is never suppressed).

module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 16,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] char_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              led,
    output logic                    frame_start
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        slotCnt_q, slotCnt_d;
    logic [DIG_W-1:0]        digIdx_q, digIdx_d;
    logic [4*NUM_DIGITS-1:0] pendChar_q, activeChar_q, activeChar_d;
    logic [NUM_DIGITS-1:0]   pendBlank_q, activeBlank_q, activeBlank_d;
    logic                    pendValid_q;
    logic [NUM_DIGITS-1:0]   leadZeroMask;
    logic                    frameEdge;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              led_q, led_d;
    logic                    frameStart_q;

    logic [3:0]              curChar;
    logic                    curBlank;
    logic                    inDead;

    // Active-low hex decode; anything unknown falls through to all-off.
    function automatic logic [6:0] decodeHex(input logic [3:0] ch);
        logic [6:0] seg;
        case (ch)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    assign frameEdge = (slotCnt_q == '0) && (digIdx_q == '0);

    // Slot counter wraps every SLOT_CYCLES; digit index advances on each wrap.
    always_comb begin
        slotCnt_d = slotCnt_q + CNT_W'(1);
        digIdx_d  = digIdx_q;
        if (slotCnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
            slotCnt_d = '0;
            if (digIdx_q == DIG_W'(NUM_DIGITS - 1)) begin
                digIdx_d = '0;
            end else begin
                digIdx_d = digIdx_q + DIG_W'(1);
            end
        end
    end

    // Leading-zero mask scans from the most significant digit down and stops
    // at the first nonzero char; digit 0 is excluded so "0" still shows.
    always_comb begin
        leadZeroMask = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic stillLeading;
            stillLeading = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (stillLeading && (pendChar_q[4*k +: 4] == 4'h0)) begin
                    leadZeroMask[k] = 1'b1;
                end else begin
                    stillLeading = 1'b0;
                end
            end
        end
`endif
    end

    // Promotion uses the next-state active data so the boundary outputs
    // already reflect the newly activated frame.
    always_comb begin
        activeChar_d  = activeChar_q;
        activeBlank_d = activeBlank_q;
        if (frameEdge && pendValid_q) begin
            activeChar_d  = pendChar_q;
            activeBlank_d = pendBlank_q | leadZeroMask;
        end
    end

    // Select the char and blank bit of the digit currently being scanned.
    always_comb begin
        curChar  = 4'h0;
        curBlank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digIdx_q == DIG_W'(k)) begin
                curChar  = activeChar_d[4*k +: 4];
                curBlank = activeBlank_d[k];
            end
        end
    end

    assign inDead = (32'(slotCnt_q) < 32'(DEAD_CYCLES));

    // A blanked digit keeps its anode asserted; only the segments go dark.
    always_comb begin
        an_d  = '1;
        led_d = 7'b1111111;
        if (!inDead) begin
            an_d  = ~(NUM_DIGITS'(1) << digIdx_q);
            led_d = curBlank ? 7'b1111111 : decodeHex(curChar);
        end
    end

    // A load on the boundary cycle re-arms pending after the promotion, so it
    // takes effect at the following boundary rather than mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotCnt_q     <= '0;
            digIdx_q      <= '0;
            pendChar_q    <= '0;
            pendBlank_q   <= '0;
            pendValid_q   <= 1'b0;
            activeChar_q  <= '0;
            activeBlank_q <= '0;
            an_q          <= '1;
            led_q         <= 7'b1111111;
            frameStart_q  <= 1'b0;
        end else begin
            slotCnt_q     <= slotCnt_d;
            digIdx_q      <= digIdx_d;
            activeChar_q  <= activeChar_d;
            activeBlank_q <= activeBlank_d;
            if (load) begin
                pendChar_q  <= char_in;
                pendBlank_q <= blank_in;
                pendValid_q <= 1'b1;
            end else if (frameEdge && pendValid_q) begin
                pendValid_q <= 1'b0;
            end
            an_q          <= an_d;
            led_q         <= led_d;
            frameStart_q  <= frameEdge;
        end
    end

    assign an          = an_q;
    assign led         = led_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (NUM_DIGITS=4, SLOT_CYCLES=16, DEAD_CYCLES=2).
// A reference model steps once per rising edge, pushes the expected outputs
// into a scoreboard queue, and the falling edge pops and compares them.

module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SC    = 16;
    localparam int DC    = 2;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] char_in;
    logic [3:0]  blank_in;
    logic [3:0]  an;
    logic [6:0]  led;
    logic        frame_start;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] led;
        logic       fs;
    } expT;

    expT sbQ[$];
    expT sbExp;
    expT mExp;

    int vectorCount = 0;
    int missCount   = 0;

    logic [6:0] segTable [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model state
    int          mEdge;
    logic [15:0] mPend, mActive;
    logic [3:0]  mPendBlank, mActiveBlank;
    logic        mPendValid;
    int          mPos, mCnt, mDig;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS  (ND),
        .SLOT_CYCLES (SC),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .load        (load),
        .blank_in    (blank_in),
        .an          (an),
        .led         (led),
        .frame_start (frame_start)
    );

    // Single point of comparison: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
        end
    endtask

    // Drive one load strobe for a single cycle, changing inputs on the falling edge.
    task automatic applyStimulus(input logic [15:0] ch, input logic [3:0] blk);
        char_in  = ch;
        blank_in = blk;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    function automatic logic [3:0] lzMask(input logic [15:0] ch);
        logic [3:0] m;
        m = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int k = 3; k >= 1; k--) begin
            if (ch[k*4 +: 4] != 4'h0) break;
            m[k] = 1'b1;
        end
`endif
        return m;
    endfunction

    // Model: position within the frame comes straight from the edge count.
    always @(posedge clk) begin
        if (reset) begin
            mEdge        = 0;
            mPend        = '0;
            mActive      = '0;
            mPendBlank   = '0;
            mActiveBlank = '0;
            mPendValid   = 1'b0;
        end else begin
            mPos = mEdge % FRAME;
            mCnt = mPos % SC;
            mDig = mPos / SC;
            if (mPos == 0 && mPendValid) begin
                mActive      = mPend;
                mActiveBlank = mPendBlank | lzMask(mPend);
                mPendValid   = 1'b0;
            end
            if (load) begin
                mPend      = char_in;
                mPendBlank = blank_in;
                mPendValid = 1'b1;
            end
            mExp.fs = (mPos == 0);
            if (mCnt < DC) begin
                mExp.an  = 4'hF;
                mExp.led = 7'h7F;
            end else begin
                mExp.an  = 4'hF & ~(4'b0001 << mDig);
                mExp.led = mActiveBlank[mDig] ? 7'h7F : segTable[mActive[mDig*4 +: 4]];
            end
            sbQ.push_back(mExp);
            mEdge++;
        end
    end

    // Scoreboard consumer: compare on the falling edge, away from updates.
    always @(negedge clk) begin
        if (reset) begin
            sbQ.delete();
        end else if (sbQ.size() > 0) begin
            sbExp = sbQ.pop_front();
            checkOutput("an", 32'(an), 32'(sbExp.an));
            checkOutput("led", 32'(led), 32'(sbExp.led));
            checkOutput("frame_start", 32'(frame_start), 32'(sbExp.fs));
        end
    end

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        char_in  = '0;
        blank_in = '0;

        // Reset held for five cycles; outputs must sit at their idle values.
        repeat (5) begin
            @(negedge clk);
            checkOutput("reset_an", 32'(an), 32'h0000000F);
            checkOutput("reset_led", 32'(led), 32'h0000007F);
            checkOutput("reset_fs", 32'(frame_start), 32'h0);
        end
        reset = 1'b0;

        // Basic frame 1234, scanned over a few frames.
        applyStimulus(16'h1234, 4'h0);
        repeat (3 * FRAME) @(negedge clk);

        // Every hex value on digit 0, one per frame.
        for (int v = 0; v < 16; v++) begin
            applyStimulus({12'h000, 4'(v)}, 4'h0);
            repeat (FRAME - 1) @(negedge clk);
        end
        repeat (FRAME) @(negedge clk);

        // Back-to-back loads mid-frame: last one wins at the next boundary.
        repeat (20) @(negedge clk);
        applyStimulus(16'hABCD, 4'h0);
        @(negedge clk);
        applyStimulus(16'hEF01, 4'h0);
        repeat (2 * FRAME) @(negedge clk);

        // Per-digit blanking keeps anodes asserted.
        applyStimulus(16'h8888, 4'b0101);
        repeat (2 * FRAME) @(negedge clk);

        // Leading-zero frames (blanked only when the feature is built in).
        applyStimulus(16'h0070, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        applyStimulus(16'h0000, 4'h0);
        repeat (2 * FRAME) @(negedge clk);

        // Reset mid-slot must force idle outputs without waiting for a clock.
        repeat (21) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_an", 32'(an), 32'h0000000F);
        checkOutput("midreset_led", 32'(led), 32'h0000007F);
        checkOutput("midreset_fs", 32'(frame_start), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Scan restarts at digit 0 with dead time, blank data after reset.
        repeat (FRAME + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
